// File: rtl/lsq_alloc_ctrl_pkg.sv
// Shared definitions for the LSQ allocator: default sizes, entry lifecycle
// encodings and the packed layout of one queued memory op.
package lsq_alloc_ctrl_pkg;

  localparam int LSQ_DEPTH = 4;
  localparam int LSQ_IDXW  = 2;
  localparam int LSQ_ROBW  = 5;
  localparam int LSQ_AW    = 32;

  // Lifecycle of one LSQ entry: FREE -> WAIT -> ISSUED -> FREE
  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ISSUED = 2'd2
  } entry_state_t;

  // Payload captured at dispatch and replayed at issue / writeback
  typedef struct packed {
    logic                is_store;
    logic [LSQ_ROBW-1:0] rob_id;
    logic [LSQ_AW-1:0]   addr;
    logic [LSQ_AW-1:0]   data;
  } entry_t;

endpackage

// File: rtl/lsq_order_fifo.sv
// Circular FIFO of entry indices recording allocation order. Clear has
// priority over push/pop. Occupancy never exceeds DEPTH because every
// pushed index was popped from a DEPTH-entry free list, so no full flag.
module lsq_order_fifo #(
  parameter int DEPTH = 4,
  parameter int IDXW  = 2
) (
  input  logic            Clk,
  input  logic            Rest,
  input  logic            Push,
  input  logic [IDXW-1:0] PushIdx,
  input  logic            Pop,
  input  logic            Clear,
  output logic            Empty,
  output logic [IDXW-1:0] HeadIdx
);

  logic [IDXW-1:0] mem_reg [DEPTH];
  logic [IDXW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [IDXW:0]   count_reg;

  function automatic logic [IDXW-1:0] ptr_inc(input logic [IDXW-1:0] p);
    return (p == IDXW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pointer and occupancy bookkeeping
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (Clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (Push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (Pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      count_reg <= count_reg + (IDXW+1)'(Push) - (IDXW+1)'(Pop);
    end
  end

  // Index storage; contents are meaningless while the slot is unoccupied
  always_ff @(posedge Clk) begin
    if (Push && !Clear) mem_reg[wr_ptr_reg] <= PushIdx;
  end

  assign Empty   = (count_reg == '0);
  assign HeadIdx = mem_reg[rd_ptr_reg];

endmodule

// File: rtl/lsq_alloc_ctrl.sv
// LSQ allocator with in-order issue. Pops free indices on dispatch, issues
// entries to memory in allocation order, writes back on response and returns
// the index to the free FIFO. Flush frees everything and requests a free
// FIFO re-initialise for one cycle.
// Optional build macro LSQ_STAT_EN adds StatStall / StatIssue counters.
// ROBW and AW must match the package widths, which fix the entry layout.
module lsq_alloc_ctrl
  import lsq_alloc_ctrl_pkg::*;
#(
  parameter int DEPTH = LSQ_DEPTH,
  parameter int IDXW  = LSQ_IDXW,
  parameter int ROBW  = LSQ_ROBW,
  parameter int AW    = LSQ_AW
) (
  input  logic            Clk,
  input  logic            Rest,
  input  logic            DispValid,
  output logic            DispReady,
  input  logic            DispIsStore,
  input  logic [AW-1:0]   DispAddr,
  input  logic [AW-1:0]   DispData,
  input  logic [ROBW-1:0] DispRobId,
  input  logic            FlEmpty,
  input  logic [IDXW-1:0] FlPreIdx,
  output logic            FlRable,
  output logic            FlWable,
  output logic [IDXW-1:0] FlDin,
  output logic            FlClean,
  output logic            MemReqValid,
  input  logic            MemReqReady,
  output logic [IDXW-1:0] MemReqIdx,
  output logic            MemReqStore,
  output logic [AW-1:0]   MemReqAddr,
  output logic [AW-1:0]   MemReqData,
  input  logic            MemRespValid,
  input  logic [IDXW-1:0] MemRespIdx,
  input  logic [AW-1:0]   MemRespData,
  output logic            WbValid,
  output logic [ROBW-1:0] WbRobId,
  output logic [AW-1:0]   WbData,
  input  logic            Flush
`ifdef LSQ_STAT_EN
  ,
  output logic [31:0]     StatStall,
  output logic [31:0]     StatIssue
`endif
);

  entry_state_t    state_reg  [DEPTH];
  entry_state_t    state_next [DEPTH];
  entry_t          entry_reg  [DEPTH];
  entry_t          disp_entry;
  entry_t          head_entry;
  logic            fifo_empty;
  logic [IDXW-1:0] head_idx;
  logic            disp_ready, disp_fire, req_valid, req_fire, resp_ok;
  logic            flclean_reg, wb_valid_reg;
  logic [ROBW-1:0] wb_rob_reg;
  logic [AW-1:0]   wb_data_reg;

  // Handshake decode; flush blocks everything for its own cycle
  assign disp_ready = !FlEmpty && !Flush && !flclean_reg;
  assign disp_fire  = DispValid && disp_ready;
  assign req_valid  = !fifo_empty && (state_reg[head_idx] == ST_WAIT) && !Flush;
  assign req_fire   = req_valid && MemReqReady;
  assign resp_ok    = MemRespValid && (state_reg[MemRespIdx] == ST_ISSUED) && !Flush;

  assign disp_entry = '{is_store: DispIsStore, rob_id: DispRobId, addr: DispAddr, data: DispData};
  assign head_entry = req_valid ? entry_reg[head_idx] : '0;

  lsq_order_fifo #(.DEPTH(DEPTH), .IDXW(IDXW)) u_order (
    .Clk     (Clk),
    .Rest    (Rest),
    .Push    (disp_fire),
    .PushIdx (FlPreIdx),
    .Pop     (req_fire),
    .Clear   (Flush),
    .Empty   (fifo_empty),
    .HeadIdx (head_idx)
  );

  // Per-entry next state; the three events target different entries
  // because a dispatched index always comes from the free FIFO
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign state_next[gi] =
        Flush                                     ? ST_FREE   :
        (disp_fire && FlPreIdx   == IDXW'(gi))    ? ST_WAIT   :
        (req_fire  && head_idx   == IDXW'(gi))    ? ST_ISSUED :
        (resp_ok   && MemRespIdx == IDXW'(gi))    ? ST_FREE   :
                                                    state_reg[gi];
    end
  endgenerate

  // Entry lifecycle state
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      for (int i = 0; i < DEPTH; i++) state_reg[i] <= ST_FREE;
    end else begin
      for (int i = 0; i < DEPTH; i++) state_reg[i] <= state_next[i];
    end
  end

  // Entry payload, written only at dispatch
  always_ff @(posedge Clk) begin
    if (disp_fire) entry_reg[FlPreIdx] <= disp_entry;
  end

  // Writeback pulse and one-cycle free FIFO clean request
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      wb_valid_reg <= 1'b0;
      wb_rob_reg   <= '0;
      wb_data_reg  <= '0;
      flclean_reg  <= 1'b0;
    end else begin
      wb_valid_reg <= resp_ok;
      flclean_reg  <= Flush;
      if (resp_ok) begin
        wb_rob_reg  <= entry_reg[MemRespIdx].rob_id;
        wb_data_reg <= entry_reg[MemRespIdx].is_store ? '0 : MemRespData;
      end
    end
  end

  assign DispReady   = disp_ready;
  assign FlRable     = disp_fire;
  assign FlWable     = resp_ok;
  assign FlDin       = resp_ok ? MemRespIdx : '0;
  assign FlClean     = flclean_reg;
  assign MemReqValid = req_valid;
  assign MemReqIdx   = req_valid ? head_idx : '0;
  assign MemReqStore = head_entry.is_store;
  assign MemReqAddr  = head_entry.addr;
  assign MemReqData  = head_entry.data;
  assign WbValid     = wb_valid_reg && !Flush;
  assign WbRobId     = wb_rob_reg;
  assign WbData      = wb_data_reg;

`ifdef LSQ_STAT_EN
  logic [31:0] stat_stall_reg, stat_issue_reg;

  // Free-running statistics, untouched by flush
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      stat_stall_reg <= '0;
      stat_issue_reg <= '0;
    end else begin
      if (DispValid && !disp_ready) stat_stall_reg <= stat_stall_reg + 32'd1;
      if (req_fire)                 stat_issue_reg <= stat_issue_reg + 32'd1;
    end
  end

  assign StatStall = stat_stall_reg;
  assign StatIssue = stat_issue_reg;
`endif

endmodule
